slave_to_master_mux: RTL and testbench

//  AHB read/response return path: routes HRDATA/HREADY/HRESP from the slave owning the current data phase

---
 rtl/slave_to_master_mux.sv | 184 ++++++++++++++++++
 tb/tb_slave_to_master_mux.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/slave_to_master_mux.sv
// AHB read/response return mux: registers the address-phase select into a data-phase select,
// routes the owning slave's HRDATA/HREADYOUT/HRESP back to the masters, and contains the bus
// default slave. Defining AHB_MUX_TIMEOUT_EN adds a wait-state watchdog that forces an ERROR.
module slave_to_master_mux #(
   parameter int NUM_SLAVES     = 4,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16,
   localparam int SEL_W         = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
   input  logic                             Hclk,
   input  logic                             Hresetn,
   input  logic [NUM_SLAVES-1:0]            Hsel,
   input  logic [1:0]                       Htrans,
   input  logic [DATA_WIDTH*NUM_SLAVES-1:0] Hrdata_S,
   input  logic [NUM_SLAVES-1:0]            Hreadyout_S,
   input  logic [NUM_SLAVES-1:0]            Hresp_S,
   output logic [DATA_WIDTH-1:0]            Hrdata,
   output logic                             Hready,
   output logic                             Hresp,
   output logic [SEL_W-1:0]                 Hslave_dp,
   output logic                             Hdefault_dp
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ERR1 = 2'b01,
      ST_ERR2 = 2'b10
   } dflt_state_e;

   dflt_state_e           state_r;
   dflt_state_e           state_next_s;
   logic                  active_dp_r;
   logic                  default_dp_r;
   logic [SEL_W-1:0]      sel_dp_r;
   logic                  addr_active_s;
   logic                  addr_unmapped_s;
   logic                  err_capture_s;
   logic [SEL_W-1:0]      addr_idx_s;
   logic                  timeout_s;
   logic [DATA_WIDTH-1:0] slave_rdata_s;
   logic                  slave_ready_s;
   logic                  slave_resp_s;

   // Lowest set bit wins when the decoder asserts more than one select.
   function automatic logic [SEL_W-1:0] lowest_index(input logic [NUM_SLAVES-1:0] sel);
      logic [SEL_W-1:0] idx;
      idx = {SEL_W{1'b0}};
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         idx = sel[i] ? i[SEL_W-1:0] : idx;
      end
      return idx;
   endfunction

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("slave_to_master_mux: TIMEOUT_CYCLES must be at least 2");
   end

   assign addr_active_s   = (Htrans == 2'b10) || (Htrans == 2'b11);
   assign addr_unmapped_s = (Hsel == {NUM_SLAVES{1'b0}});
   assign err_capture_s   = addr_active_s && addr_unmapped_s;
   assign addr_idx_s      = lowest_index(Hsel);
   assign Hslave_dp       = sel_dp_r;
   assign Hdefault_dp     = default_dp_r;

   // Address-to-data phase capture; a stalled bus (Hready=0) holds the data phase.
   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         active_dp_r  <= 1'b0;
         sel_dp_r     <= {SEL_W{1'b0}};
         default_dp_r <= 1'b0;
      end else if (Hready) begin
         active_dp_r  <= addr_active_s;
         sel_dp_r     <= addr_idx_s;
         default_dp_r <= err_capture_s;
      end else begin
         active_dp_r  <= active_dp_r;
         sel_dp_r     <= sel_dp_r;
         default_dp_r <= default_dp_r;
      end
   end

   // Response fields of the slave owning the current data phase.
   always_comb begin
      slave_rdata_s = {DATA_WIDTH{1'b0}};
      slave_ready_s = 1'b1;
      slave_resp_s  = 1'b0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         slave_rdata_s = (sel_dp_r == i[SEL_W-1:0]) ? Hrdata_S[i*DATA_WIDTH +: DATA_WIDTH] : slave_rdata_s;
         slave_ready_s = (sel_dp_r == i[SEL_W-1:0]) ? Hreadyout_S[i] : slave_ready_s;
         slave_resp_s  = (sel_dp_r == i[SEL_W-1:0]) ? Hresp_S[i] : slave_resp_s;
      end
   end

`ifdef AHB_MUX_TIMEOUT_EN
   localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] wait_cnt_r;

   // The cycle the counter sits at its limit is itself the first ERROR cycle.
   assign timeout_s = active_dp_r && !default_dp_r && (state_r == ST_IDLE) && (wait_cnt_r == WAIT_LAST);

   // Counts wait states of a mapped data phase; any completed or forced cycle restarts it.
   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         wait_cnt_r <= {CNT_W{1'b0}};
      end else if (Hready || timeout_s) begin
         wait_cnt_r <= {CNT_W{1'b0}};
      end else if (active_dp_r && !default_dp_r) begin
         wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         wait_cnt_r <= wait_cnt_r;
      end
   end
`else
   assign timeout_s = 1'b0;
`endif

   // Error-response state register.
   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Error-response sequencing: a forced timeout enters at the second cycle since its first
   // cycle is produced directly from the counter.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (timeout_s) begin
               state_next_s = ST_ERR2;
            end else if (Hready && err_capture_s) begin
               state_next_s = ST_ERR1;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_ERR1: state_next_s = ST_ERR2;
         ST_ERR2: begin
            if (err_capture_s) begin
               state_next_s = ST_ERR1;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Bus response select, combinational from registered data-phase state.
   always_comb begin
      Hready = 1'b1;
      Hresp  = 1'b0;
      Hrdata = {DATA_WIDTH{1'b0}};
      case (state_r)
         ST_ERR1: begin
            Hready = 1'b0;
            Hresp  = 1'b1;
         end
         ST_ERR2: begin
            Hready = 1'b1;
            Hresp  = 1'b1;
         end
         default: begin
            if (timeout_s) begin
               Hready = 1'b0;
               Hresp  = 1'b1;
            end else if (active_dp_r && !default_dp_r) begin
               Hready = slave_ready_s;
               Hresp  = slave_resp_s;
               Hrdata = slave_rdata_s;
            end else begin
               Hready = 1'b1;
               Hresp  = 1'b0;
            end
         end
      endcase
   end

endmodule

// File: tb/tb_slave_to_master_mux.sv
// Directed bench for slave_to_master_mux: a transaction-level model of data-phase ownership
// is checked against the DUT on every falling edge, plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_slave_to_master_mux;

   localparam int NS  = 4;
   localparam int DW  = 32;
   localparam int TMO = 16;
   localparam int OWN_NONE = -1;
   localparam int OWN_DEF  = -2;

   logic          Hclk = 1'b0;
   logic          Hresetn = 1'b0;
   logic [NS-1:0] Hsel = '0;
   logic [1:0]    Htrans = 2'b00;
   logic [DW*NS-1:0] Hrdata_S;
   logic [NS-1:0] Hreadyout_S = 4'hF;
   logic [NS-1:0] Hresp_S = 4'h0;
   logic [DW-1:0] Hrdata;
   logic          Hready;
   logic          Hresp;
   logic [1:0]    Hslave_dp;
   logic          Hdefault_dp;

   int n_cmp = 0;
   int n_bad = 0;

   // model: who owns the data phase and how many cycles it has lasted
   int   own = OWN_NONE;
   int   cyc = 0;
   int   sel_last = 0;
   logic dflt_last = 1'b0;

   slave_to_master_mux #(
      .NUM_SLAVES(NS), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .Hclk(Hclk), .Hresetn(Hresetn), .Hsel(Hsel), .Htrans(Htrans),
      .Hrdata_S(Hrdata_S), .Hreadyout_S(Hreadyout_S), .Hresp_S(Hresp_S),
      .Hrdata(Hrdata), .Hready(Hready), .Hresp(Hresp),
      .Hslave_dp(Hslave_dp), .Hdefault_dp(Hdefault_dp)
   );

   always #5 Hclk = ~Hclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int lowest(input logic [NS-1:0] s);
      for (int i = 0; i < NS; i++) begin
         if (s[i]) return i;
      end
      return -1;
   endfunction

   // {ready, resp, data} the bus must show in the current cycle
   function automatic logic [DW+1:0] model_out();
      logic r;
      logic p;
      logic [DW-1:0] d;
      r = 1'b1; p = 1'b0; d = '0;
      if (own == OWN_DEF) begin
         p = 1'b1;
         r = (cyc != 0);
      end else if (own >= 0) begin
`ifdef AHB_MUX_TIMEOUT_EN
         if (cyc >= TMO - 1) begin
            p = 1'b1;
            r = (cyc != TMO - 1);
         end else
`endif
         begin
            r = Hreadyout_S[own];
            p = Hresp_S[own];
            d = Hrdata_S[own*DW +: DW];
         end
      end
      return {r, p, d};
   endfunction

   function automatic logic model_ready();
      logic [DW+1:0] e;
      e = model_out();
      return e[DW+1];
   endfunction

   always @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         own <= OWN_NONE; cyc <= 0; sel_last <= 0; dflt_last <= 1'b0;
      end else if (model_ready()) begin
         sel_last  <= (lowest(Hsel) < 0) ? 0 : lowest(Hsel);
         own       <= !Htrans[1] ? OWN_NONE : ((lowest(Hsel) < 0) ? OWN_DEF : lowest(Hsel));
         dflt_last <= Htrans[1] && (lowest(Hsel) < 0);
         cyc       <= 0;
      end else begin
         cyc <= cyc + 1;
      end
   end

   always @(negedge Hclk) begin : cmp
      logic [DW+1:0] e;
      e = model_out();
      check("hready", {31'd0, Hready}, {31'd0, e[DW+1]});
      check("hresp", {31'd0, Hresp}, {31'd0, e[DW]});
      check("hrdata", Hrdata, e[DW-1:0]);
      check("hslave_dp", {30'd0, Hslave_dp}, sel_last);
      check("hdefault_dp", {31'd0, Hdefault_dp}, {31'd0, dflt_last});
   end

   task automatic step(input logic [3:0] sel, input logic [1:0] tr,
                       input logic [3:0] rdy, input logic [3:0] rsp);
      @(posedge Hclk);
      #1;
      Hsel = sel; Htrans = tr; Hreadyout_S = rdy; Hresp_S = rsp;
      #3;
   endtask

   initial begin
      int n_wait;
      int n_err;
      for (int k = 0; k < NS; k++) Hrdata_S[k*DW +: DW] = 32'hCAFE_0000 + k;

      // reset state
      #12;
      check("rst_hready", {31'd0, Hready}, 32'd1);
      check("rst_hresp", {31'd0, Hresp}, 32'd0);
      check("rst_hrdata", Hrdata, 32'd0);
      check("rst_hslave_dp", {30'd0, Hslave_dp}, 32'd0);
      check("rst_hdefault_dp", {31'd0, Hdefault_dp}, 32'd0);
      Hresetn = 1'b1;

      // single zero-wait read of slave 2
      step(4'b0100, 2'b10, 4'hF, 4'h0);
      step(4'b0000, 2'b00, 4'hF, 4'h0);
      check("rd2_data", Hrdata, 32'hCAFE_0002);
      check("rd2_slave_dp", {30'd0, Hslave_dp}, 32'd2);
      check("rd2_ready", {31'd0, Hready}, 32'd1);

      // slave 1 with three wait states, slave 3 address held behind it
      step(4'b0010, 2'b10, 4'hF, 4'h0);
      step(4'b1000, 2'b10, 4'b1101, 4'h0);
      check("wait1_ready", {31'd0, Hready}, 32'd0);
      step(4'b1000, 2'b10, 4'b1101, 4'h0);
      step(4'b1000, 2'b10, 4'b1101, 4'h0);
      check("wait3_slave_dp", {30'd0, Hslave_dp}, 32'd1);
      step(4'b1000, 2'b10, 4'hF, 4'h0);
      check("wait_done_data", Hrdata, 32'hCAFE_0001);
      step(4'b0000, 2'b00, 4'hF, 4'h0);
      check("after_wait_slave_dp", {30'd0, Hslave_dp}, 32'd3);
      check("after_wait_data", Hrdata, 32'hCAFE_0003);

      // unmapped NONSEQ, chained straight into another one from ERR2
      step(4'b0000, 2'b10, 4'hF, 4'h0);
      step(4'b0000, 2'b10, 4'hF, 4'h0);
      check("err1_ready", {31'd0, Hready}, 32'd0);
      check("err1_resp", {31'd0, Hresp}, 32'd1);
      check("err1_default_dp", {31'd0, Hdefault_dp}, 32'd1);
      step(4'b0000, 2'b10, 4'hF, 4'h0);
      check("err2_ready", {31'd0, Hready}, 32'd1);
      check("err2_resp", {31'd0, Hresp}, 32'd1);
      step(4'b0000, 2'b00, 4'hF, 4'h0);
      check("chain_err1_ready", {31'd0, Hready}, 32'd0);
      step(4'b0000, 2'b01, 4'hF, 4'h0);
      step(4'b0000, 2'b00, 4'hF, 4'h0);
      check("unmapped_busy_resp", {31'd0, Hresp}, 32'd0);
      check("unmapped_busy_default_dp", {31'd0, Hdefault_dp}, 32'd0);

      // multiple selects, then back-to-back slave 0 / slave 3
      step(4'b0110, 2'b10, 4'hF, 4'h0);
      step(4'b0001, 2'b10, 4'hF, 4'h0);
      check("multi_sel_slave_dp", {30'd0, Hslave_dp}, 32'd1);
      check("multi_sel_data", Hrdata, 32'hCAFE_0001);
      step(4'b1000, 2'b11, 4'hF, 4'b0001);
      check("b2b_s0_data", Hrdata, 32'hCAFE_0000);
      check("b2b_s0_resp", {31'd0, Hresp}, 32'd1);
      step(4'b0000, 2'b00, 4'hF, 4'h0);
      check("b2b_s3_data", Hrdata, 32'hCAFE_0003);
      check("b2b_s3_ready", {31'd0, Hready}, 32'd1);

      // slave 2 never ready
      n_wait = 0;
      n_err  = 0;
      step(4'b0100, 2'b10, 4'hF, 4'h0);
      for (int c = 0; c < 100; c++) begin
         step(4'b0000, 2'b00, 4'b1011, 4'h0);
         if (Hready == 1'b0) n_wait++;
         if (Hresp == 1'b1) n_err++;
      end
`ifdef AHB_MUX_TIMEOUT_EN
      check("timeout_wait_cycles", n_wait, 32'd16);
      check("timeout_err_cycles", n_err, 32'd2);
`else
      check("stall_wait_cycles", n_wait, 32'd100);
      check("stall_err_cycles", n_err, 32'd0);
`endif
      step(4'b0000, 2'b00, 4'hF, 4'h0);
      check("stall_release_ready", {31'd0, Hready}, 32'd1);

      // async reset in the middle of a wait state
      step(4'b0010, 2'b10, 4'hF, 4'h0);
      step(4'b0000, 2'b00, 4'b1101, 4'h0);
      check("pre_reset_ready", {31'd0, Hready}, 32'd0);
      Hresetn = 1'b0;
      #0.5;
      check("async_rst_ready", {31'd0, Hready}, 32'd1);
      check("async_rst_resp", {31'd0, Hresp}, 32'd0);
      check("async_rst_data", Hrdata, 32'd0);
      check("async_rst_slave_dp", {30'd0, Hslave_dp}, 32'd0);
      step(4'b0000, 2'b00, 4'hF, 4'h0);
      Hresetn = 1'b1;
      step(4'b0001, 2'b10, 4'hF, 4'h0);
      step(4'b0000, 2'b00, 4'hF, 4'h0);
      check("post_reset_data", Hrdata, 32'hCAFE_0000);
      step(4'b0000, 2'b00, 4'hF, 4'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
